logic_accum_unit: RTL and testbench
===================================

// Module: logic_accum_unit
// PURPOSE
//  Parametrised bitwise logic engine (XOR/AND/OR/XNOR) with valid/ready handshake
//  and a registered output stage. Adds an accumulate mode folding a burst of results
//  into a running XOR (checksum/parity scrub), emitted on the burst's last beat.
//  Sits beside the ALU as a multi-beat helper for the execute stage and the test DMA.
// PARAMETERS
//  WIDTH       16   data width in bits (>=2)
//  ACC_INIT    0    accumulator value after reset and after each completed burst (WIDTH bits)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_op      in   2      00 XOR, 01 AND, 10 OR, 11 XNOR
//  in_accum   in   1      1 = beat belongs to an accumulate burst
//  in_last    in   1      final beat of burst (ignored when in_accum=0)
//  out_valid  out  1      out_data/out_parity valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  result
//  out_parity out  1      ^out_data (even-parity bit of result)
//  acc_busy   out  1      high while in ACCUM state (burst open)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_parity=0, acc_busy=0, acc=ACC_INIT, state=IDLE.
//  - Handshake: beat accepted when in_valid&&in_ready; result leaves when out_valid&&out_ready.
//    in_ready = !out_valid || out_ready (combinational; full-throughput pass-through).
//  - out_data/out_parity stable while out_valid && !out_ready.
//  - r = op(in_a,in_b) bitwise, WIDTH bits, no carries.
//  - in_accum=0: out_data <= r next cycle, out_valid<=1; latency 1; acc/state unchanged.
//  - in_accum=1, in_last=0: acc <= acc ^ r; state->ACCUM; no output beat; out_valid
//    drops if current output is consumed this cycle.
//  - in_accum=1, in_last=1: out_data <= acc ^ r, out_valid<=1; acc<=ACC_INIT; state->IDLE.
//    A single-beat burst (first beat has last=1) yields ACC_INIT^r.
//  - FSM: IDLE -(accum&!last)-> ACCUM; ACCUM -(accum&last)-> IDLE; else hold.
//  - Non-accum beat inside an open burst passes through; acc and ACCUM state preserved.
//  - in_op may differ beat to beat within a burst; each beat uses its own op.
//  - out_valid && !out_ready: in_ready=0 for all beat types (non-last accum beats too).
//  - Simultaneous pop and push: new result replaces old in same cycle, out_valid stays 1.
//  - Reset mid-burst: partial acc discarded, pending output dropped, back to reset values.
// STRUCTURE
//  - logic_unit_pkg: op encodings OP_XOR/OP_AND/OP_OR/OP_XNOR (2-bit), FSM state type.
//  - Sub-module logic_op_comb #(WIDTH): purely combinational r = op(a,b).
//  - Top holds acc register, output register, 2-state FSM, handshake logic.
// TESTING
//  1 XOR pass: a=16'hF0F0 b=16'h0FF0 op=00 accum=0 -> next cycle out_data=16'hFF00, parity=0.
//  2 Backpressure: out_ready=0, push a=FFFF b=0000 op=10 -> out_data=FFFF held, in_ready=0
//    until out_ready=1; second beat then accepted same cycle as pop, no bubble.
//  3 Burst: XOR beats (1234,0000),(00FF,0000),last (F000,0000) -> one output E2CB,
//    acc_busy 1 during burst, 0 after; no output on first two beats.
//  4 Interleave: open burst with 00AA, inject accum=0 AND FFFF&0F0F -> out 0F0F;
//    finish burst last (0055,0000) -> out 00FF.
//  5 Reset mid-burst: two accum beats, assert rst -> out_valid=0, acc_busy=0; new
//    single-beat burst last (1111,0000) -> out 1111 (ACC_INIT=0).
//  6 WIDTH=8 build: XNOR a=8'hA5 b=8'hA5 -> out 8'hFF, out_parity=0; random stream vs model.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared encodings for the bitwise logic / accumulate unit: operation codes and FSM states.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_XOR  = 2'b00,
        OP_AND  = 2'b01,
        OP_OR   = 2'b10,
        OP_XNOR = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise operator: r = op(a, b), no carries between bit lanes.
module logic_op_comb
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r
);

    always_comb begin
        // NOTE: default first so every path assigns r and no latch is inferred.
        r = '0;
        case (op_e'(op))
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XNOR: r = ~(a ^ b);
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/logic_accum_unit.sv
// Bitwise logic engine with valid/ready handshake, registered output and an
// accumulate mode that folds a burst into a running XOR emitted on the last beat.
module logic_accum_unit
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_accum,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             acc_busy
);

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] out_data_d;
    state_e           state_q;
    state_e           state_d;

    logic accept;
    logic pop;
    logic push;
    logic open_beat;
    logic close_beat;

    // A stalled output blocks every beat type, including non-emitting accumulate beats.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign open_beat  = accept && in_accum && !in_last;
    assign close_beat = accept && in_accum && in_last;
    assign push       = accept && (!in_accum || in_last);

    logic_op_comb #(
        .WIDTH (WIDTH)
    ) u_op (
        .a  (in_a),
        .b  (in_b),
        .op (in_op),
        .r  (r)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = r;
        acc_busy   = (state_q == ST_ACCUM);
        if (open_beat) begin
            acc_d   = acc_q ^ r;
            state_d = ST_ACCUM;
        end else if (close_beat) begin
            acc_d      = ACC_INIT;
            state_d    = ST_IDLE;
            out_data_d = acc_q ^ r;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= ACC_INIT;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // A push in the same cycle as a pop replaces the result, keeping full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= 1'b0;
        end else if (push) begin
            out_valid  <= 1'b1;
            out_data   <= out_data_d;
            out_parity <= ^out_data_d;
        end else if (pop) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_accum_unit.sv
// Directed and randomized checks of logic_accum_unit (WIDTH=16 and WIDTH=8 builds).
module tb_logic_accum_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv, ir, ordy, ov, opar, busy, accum, last;
    logic [15:0] a, b, od;
    logic [1:0]  op;

    logic       iv8, ir8, ordy8, ov8, opar8, busy8, accum8, last8;
    logic [7:0] a8, b8, od8;
    logic [1:0] op8;

    int compared   = 0;
    int mismatched = 0;

    logic_accum_unit #(.WIDTH(16)) dut16 (
        .clk (clk), .rst (rst),
        .in_valid (iv), .in_ready (ir), .in_a (a), .in_b (b), .in_op (op),
        .in_accum (accum), .in_last (last),
        .out_valid (ov), .out_ready (ordy), .out_data (od), .out_parity (opar),
        .acc_busy (busy)
    );

    logic_accum_unit #(.WIDTH(8)) dut8 (
        .clk (clk), .rst (rst),
        .in_valid (iv8), .in_ready (ir8), .in_a (a8), .in_b (b8), .in_op (op8),
        .in_accum (accum8), .in_last (last8),
        .out_valid (ov8), .out_ready (ordy8), .out_data (od8), .out_parity (opar8),
        .acc_busy (busy8)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one beat onto the 16-bit unit at the falling edge.
    task automatic beat(input logic v, input logic [15:0] a_i, input logic [15:0] b_i,
                        input logic [1:0] op_i, input logic acc_i, input logic last_i);
        @(negedge clk);
        iv = v; a = a_i; b = b_i; op = op_i; accum = acc_i; last = last_i;
    endtask

    function automatic logic [15:0] ref_op(input logic [1:0] o, input logic [15:0] x,
                                           input logic [15:0] y);
        case (o)
            2'd0:    ref_op = x ^ y;
            2'd1:    ref_op = x & y;
            2'd2:    ref_op = x | y;
            default: ref_op = ~(x ^ y);
        endcase
    endfunction

    // Reference model state, index 0 = WIDTH 16, index 1 = WIDTH 8.
    logic [15:0] m_data [2];
    logic [15:0] m_acc  [2];
    logic        m_valid[2];
    logic        m_busy [2];
    logic [15:0] mask   [2];

    initial begin
        rst = 1'b1;
        iv = 0; ordy = 1; a = 0; b = 0; op = 0; accum = 0; last = 0;
        iv8 = 0; ordy8 = 1; a8 = 0; b8 = 0; op8 = 0; accum8 = 0; last8 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",  16'(ov),   16'd0);
        check("rst_out_data",   od,        16'h0000);
        check("rst_out_parity", 16'(opar), 16'd0);
        check("rst_acc_busy",   16'(busy), 16'd0);
        check("rst_in_ready",   16'(ir),   16'd1);
        @(negedge clk);
        rst = 1'b0;

        // XOR pass-through, latency 1
        beat(1, 16'hF0F0, 16'h0FF0, 2'b00, 0, 0);
        @(posedge clk); #1;
        check("xor_valid",  16'(ov),   16'd1);
        check("xor_data",   od,        16'hFF00);
        check("xor_parity", 16'(opar), 16'd0);

        // Backpressure: result held, input blocked, then pop+push with no bubble
        ordy = 1'b1;
        beat(1, 16'hFFFF, 16'h0000, 2'b10, 0, 0);
        @(posedge clk); #1;
        check("bp_first_data", od, 16'hFFFF);
        beat(1, 16'h1234, 16'h0000, 2'b00, 0, 0);
        ordy = 1'b0;
        #1;
        check("bp_in_ready_low", 16'(ir), 16'd0);
        @(posedge clk); #1;
        check("bp_held_data",  od,      16'hFFFF);
        check("bp_held_valid", 16'(ov), 16'd1);
        @(negedge clk);
        ordy = 1'b1;
        #1;
        check("bp_in_ready_high", 16'(ir), 16'd1);
        @(posedge clk); #1;
        check("bp_second_data",  od,      16'h1234);
        check("bp_second_valid", 16'(ov), 16'd1);
        beat(0, 16'h0000, 16'h0000, 2'b00, 0, 0);
        @(posedge clk); #1;
        check("bp_drained", 16'(ov), 16'd0);

        // Three-beat XOR burst
        beat(1, 16'h1234, 16'h0000, 2'b00, 1, 0);
        @(posedge clk); #1;
        check("burst_b1_valid", 16'(ov),   16'd0);
        check("burst_b1_busy",  16'(busy), 16'd1);
        beat(1, 16'h00FF, 16'h0000, 2'b00, 1, 0);
        @(posedge clk); #1;
        check("burst_b2_valid", 16'(ov),   16'd0);
        check("burst_b2_busy",  16'(busy), 16'd1);
        beat(1, 16'hF000, 16'h0000, 2'b00, 1, 1);
        @(posedge clk); #1;
        check("burst_out_valid",  16'(ov),   16'd1);
        check("burst_out_data",   od,        16'hE2CB);
        check("burst_out_parity", 16'(opar), 16'd1);
        check("burst_end_busy",   16'(busy), 16'd0);

        // Non-accum beat inside an open burst
        beat(1, 16'h00AA, 16'h0000, 2'b00, 1, 0);
        @(posedge clk); #1;
        check("ilv_open_valid", 16'(ov),   16'd0);
        check("ilv_open_busy",  16'(busy), 16'd1);
        beat(1, 16'hFFFF, 16'h0F0F, 2'b01, 0, 0);
        @(posedge clk); #1;
        check("ilv_pass_data", od,        16'h0F0F);
        check("ilv_pass_busy", 16'(busy), 16'd1);
        beat(1, 16'h0055, 16'h0000, 2'b00, 1, 1);
        @(posedge clk); #1;
        check("ilv_close_data", od,        16'h00FF);
        check("ilv_close_busy", 16'(busy), 16'd0);

        // Reset mid-burst with a stalled output pending
        beat(1, 16'h0003, 16'h0000, 2'b00, 1, 0);
        beat(1, 16'h0004, 16'h0000, 2'b00, 1, 0);
        beat(1, 16'hABCD, 16'h0000, 2'b00, 0, 0);
        @(posedge clk); #1;
        check("mid_pending_valid", 16'(ov), 16'd1);
        @(negedge clk);
        iv = 1'b0;
        ordy = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 16'(ov),   16'd0);
        check("mid_rst_busy",  16'(busy), 16'd0);
        check("mid_rst_data",  od,        16'h0000);
        @(negedge clk);
        rst = 1'b0;
        ordy = 1'b1;
        beat(1, 16'h1111, 16'h0000, 2'b00, 1, 1);
        @(posedge clk); #1;
        check("post_rst_data",  od,      16'h1111);
        check("post_rst_valid", 16'(ov), 16'd1);

        // WIDTH=8 XNOR
        beat(0, 16'h0000, 16'h0000, 2'b00, 0, 0);
        iv8 = 1; a8 = 8'hA5; b8 = 8'hA5; op8 = 2'b11; accum8 = 0; last8 = 0;
        @(posedge clk); #1;
        check("w8_xnor_valid",  16'(ov8),   16'd1);
        check("w8_xnor_data",   16'(od8),   16'h00FF);
        check("w8_xnor_parity", 16'(opar8), 16'd0);
        @(negedge clk);
        iv8 = 0;
        @(posedge clk); #1;
        check("idle16_valid", 16'(ov),  16'd0);
        check("idle8_valid",  16'(ov8), 16'd0);

        // Random stream on both builds against the model
        mask[0] = 16'hFFFF;
        mask[1] = 16'h00FF;
        for (int k = 0; k < 2; k++) begin
            m_data[k] = '0; m_acc[k] = '0; m_valid[k] = 0; m_busy[k] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            iv    = ($urandom_range(0, 3) != 0);
            ordy  = ($urandom_range(0, 9) < 7);
            a     = 16'($urandom);
            b     = 16'($urandom);
            op    = 2'($urandom_range(0, 3));
            accum = 1'($urandom_range(0, 1));
            last  = ($urandom_range(0, 2) == 0);
            iv8 = iv; ordy8 = ordy; a8 = a[7:0]; b8 = b[7:0];
            op8 = op; accum8 = accum; last8 = last;
            #1;
            for (int k = 0; k < 2; k++) begin
                check(k == 0 ? "rnd16_in_ready" : "rnd8_in_ready",
                      16'(k == 0 ? ir : ir8), 16'(!m_valid[k] || ordy));
                check(k == 0 ? "rnd16_out_valid" : "rnd8_out_valid",
                      16'(k == 0 ? ov : ov8), 16'(m_valid[k]));
                check(k == 0 ? "rnd16_busy" : "rnd8_busy",
                      16'(k == 0 ? busy : busy8), 16'(m_busy[k]));
                if (m_valid[k]) begin
                    check(k == 0 ? "rnd16_data" : "rnd8_data",
                          k == 0 ? od : {8'h00, od8}, m_data[k]);
                    check(k == 0 ? "rnd16_parity" : "rnd8_parity",
                          16'(k == 0 ? opar : opar8), 16'(^m_data[k]));
                end
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                logic        take;
                logic        popped;
                logic [15:0] res;
                take   = iv && (!m_valid[k] || ordy);
                popped = m_valid[k] && ordy;
                res    = ref_op(op, a, b) & mask[k];
                if (take && accum && !last) begin
                    m_acc[k]  = m_acc[k] ^ res;
                    m_busy[k] = 1'b1;
                    if (popped) m_valid[k] = 1'b0;
                end else if (take && accum) begin
                    m_data[k]  = m_acc[k] ^ res;
                    m_valid[k] = 1'b1;
                    m_acc[k]   = '0;
                    m_busy[k]  = 1'b0;
                end else if (take) begin
                    m_data[k]  = res;
                    m_valid[k] = 1'b1;
                end else if (popped) begin
                    m_valid[k] = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
